latch_bank_arb: RTL and testbench
=================================

LATCH_BANK_ARB -- requirements
Module: latch_bank_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one D-latch bank.
REQ-002 Parameter WIDTH, default 8, latch bank data width in bits.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  N_REQ  per-requester write request, level, bit i = requester i.
REQ-006 din  input  N_REQ*WIDTH  flat data bus, slice [i*WIDTH +: WIDTH] = requester i data.
REQ-007 gnt  output  N_REQ  one-hot grant, at most one bit high.
REQ-008 ack  output  N_REQ  one-hot, one-cycle completion pulse to granted requester.
REQ-009 en  output  1  latch enable to the latch bank.
REQ-010 d_out  output  WIDTH  data to latch bank D inputs.
REQ-011 q_in  input  WIDTH  latch bank Q readback.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  sticky readback-mismatch flag.

Function
REQ-014 FSM states IDLE, LOAD, CHECK; state, gnt, d_out, en, ack, err, pointer all registered.
REQ-015 IDLE: if req != 0 at a rising edge, winner = first set req bit searching upward (wrapping) from pointer; gnt[winner]=1, d_out=din slice of winner, next state LOAD; else stay IDLE, outputs unchanged except ack=0.
REQ-016 LOAD: en=1 for exactly this one cycle, d_out held, gnt held; next state CHECK unconditionally.
REQ-017 CHECK: en=0, d_out held; at the rising edge leaving CHECK, compare q_in to d_out; mismatch sets err; ack[winner]=1 for the following cycle; gnt=0; pointer=(winner+1) mod N_REQ; next state IDLE.
REQ-018 Latency: req sampled at edge k -> gnt high after edge k, en high in cycle k+1..k+2 window (LOAD), ack high cycle after edge k+2; transaction = 3 cycles, back-to-back requests served every 3 cycles.
REQ-019 Round-robin fairness: with all req bits held high, grants rotate 0,1,2,3,0,... ; no requester waits more than N_REQ-1 transactions.
REQ-020 Requester holds req and din until its ack; req dropping after grant does not abort the transaction (it completes, ack still issued).
REQ-021 din changing during LOAD/CHECK is ignored; d_out is the value captured in IDLE.
REQ-022 A requester whose req stays high after ack is eligible again in the next IDLE but only after lower-pointer-order requesters per REQ-019.
REQ-023 ack and gnt never overlap for the same requester; en never high outside LOAD.
REQ-024 err clears only on reset.

Reset
REQ-025 rst high forces immediately (no clock needed): state=IDLE, gnt=0, ack=0, en=0, d_out=0, busy=0, err=0, pointer=0.
REQ-026 Reset mid-transaction abandons it: no ack issued, latch contents undefined to this block, arbitration restarts at requester 0.
REQ-027 First arbitration occurs at the first rising edge after rst deasserts.

Structure
REQ-028 Shared package holds FSM state encoding constants (IDLE=2'd0, LOAD=2'd1, CHECK=2'd2) and default N_REQ/WIDTH.
REQ-029 One sub-module rr_pick: combinational round-robin winner selection (req, pointer -> one-hot winner, valid); rest in top.
REQ-030 Testbench instantiates the existing D-latch as the latch bank (per bit) with en/d_out/q_in wired, clk period 10 ns.

Verification
REQ-031 Single request: req=4'b0100, din slice2=8'hA5 -> gnt=4'b0100 next cycle, en one cycle, q_in=8'hA5, ack=4'b0100 one cycle, err=0.
REQ-032 All requesting: req=4'b1111 for 12 transactions -> grant order 0,1,2,3,0,1,2,3,0,1,2,3, one transaction per 3 cycles.
REQ-033 Pointer wrap: pointer=3 after serving req2, then req=4'b1001 -> requester 3 granted before 0.
REQ-034 Mismatch: force q_in=8'h00 while d_out=8'h3C in CHECK -> err=1, stays 1 across subsequent good transactions until rst.
REQ-035 Reset mid-LOAD: assert rst during en=1 -> en, gnt, busy drop same time step, no ack, next grant starts from requester 0.
REQ-036 Req dropped after grant: req1 high one cycle only -> transaction completes, ack[1]=1, next IDLE with req=0 stays idle.

Source files
------------

// File: rtl/latch_bank_arb_pkg.sv
// rtl/latch_bank_arb_pkg.sv - shared FSM encoding, default sizes and pointer-width helper
package latch_bank_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_bank_arb_if.sv
// rtl/latch_bank_arb_if.sv - requester-side handshake bundle (req/din in, gnt/ack out)
interface latch_bank_arb_if #(
  parameter int N_REQ = latch_bank_arb_pkg::N_REQ_DEF,
  parameter int WIDTH = latch_bank_arb_pkg::WIDTH_DEF
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] din;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;

  modport master (
    output req,
    output din,
    input  gnt,
    input  ack
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output ack
  );

endinterface

// File: rtl/latch_bank_arb_rr_pick.sv
// rtl/latch_bank_arb_rr_pick.sv - combinational round-robin winner search starting at ptr_i
module latch_bank_arb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  logic             found;
  logic [PTR_W-1:0] j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Search upward from the pointer, wrapping at N_REQ.
      j = PTR_W'((int'(ptr_i) + k) % N_REQ);
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_bank_arb.sv
// rtl/latch_bank_arb.sv - round-robin arbiter granting one requester at a time a write into a shared D-latch bank
module latch_bank_arb
  import latch_bank_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  latch_bank_arb_if.slave  bus,
  output logic             en_o,
  output logic [WIDTH-1:0] d_out_o,
  input  logic [WIDTH-1:0] q_in_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int PTR_W = ptr_width(N_REQ);

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] ack_q;
  logic             en_q;
  logic             busy_q;
  logic             err_q;
  logic [WIDTH-1:0] d_out_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] win_q;

  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] din_sel_d;
  logic [PTR_W-1:0] ptr_d;

  latch_bank_arb_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_onehot),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    din_sel_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_onehot[i]) din_sel_d = bus.din[i*WIDTH +: WIDTH];
    end
  end

  assign ptr_d = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      d_out_q <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= '0;
          if (pick_valid) begin
            gnt_q   <= pick_onehot;
            win_q   <= pick_idx;
            d_out_q <= din_sel_d;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          en_q    <= 1'b0;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          // The latch has been transparent for the LOAD cycle, so Q must equal D now.
          if (q_in_i != d_out_q) err_q <= 1'b1;
          ack_q   <= gnt_q;
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;
  assign en_o    = en_q;
  assign d_out_o = d_out_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_latch_bank_arb.sv
// tb/tb_latch_bank_arb.sv - directed and random stimulus against a transaction-phase reference model
module tb_latch_bank_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         busy;
  logic         err;
  logic         corrupt;
  logic [W-1:0] d_out;
  logic [W-1:0] q_in;
  logic [W-1:0] latch_q;

  latch_bank_arb_if #(.N_REQ(N), .WIDTH(W)) bus ();

  latch_bank_arb #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .en_o    (en),
    .d_out_o (d_out),
    .q_in_i  (q_in),
    .busy_o  (busy),
    .err_o   (err)
  );

  always_latch begin
    if (en) latch_q = d_out;
  end

  assign q_in = corrupt ? '0 : latch_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  // Reference model: phase 0 waiting, 1 writing, 2 verifying.
  int       m_phase;
  int       m_win;
  int       m_ptr;
  int       m_ack;
  logic [W-1:0] m_data;
  bit       m_err;
  int       grant_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic compare_all();
    check_eq("gnt",   32'(bus.gnt), (m_phase != 0) ? (32'd1 << m_win) : 32'd0);
    check_eq("ack",   32'(bus.ack), (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0);
    check_eq("en",    32'(en),      32'(m_phase == 1));
    check_eq("busy",  32'(busy),    32'(m_phase != 0));
    check_eq("d_out", 32'(d_out),   32'(m_data));
    check_eq("err",   32'(err),     32'(m_err));
    check_eq("ack_gnt_overlap", 32'(bus.ack & bus.gnt), 32'd0);
  endtask

  task automatic step();
    int w;
    m_ack = -1;
    case (m_phase)
      0: begin
        w = pick(bus.req);
        if (w >= 0) begin
          m_win   = w;
          m_data  = bus.din[w*W +: W];
          m_phase = 1;
          grant_log.push_back(w);
        end
      end
      1: m_phase = 2;
      default: begin
        if (corrupt && m_data != '0) m_err = 1'b1;
        m_ack   = m_win;
        m_ptr   = (m_win + 1) % N;
        m_phase = 0;
      end
    endcase
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    m_phase = 0;
    m_win   = 0;
    m_ptr   = 0;
    m_ack   = -1;
    m_data  = '0;
    m_err   = 1'b0;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    corrupt  = 1'b0;
    bus.req  = '0;
    bus.din  = '0;
    apply_reset();

    // Single request from requester 2.
    bus.din = {8'h11, 8'hA5, 8'h22, 8'h33};
    bus.req = 4'b0100;
    step();
    check_eq("single_gnt", 32'(bus.gnt), 32'h4);
    check_eq("single_en", 32'(en), 32'h1);
    step();
    check_eq("single_q_in", 32'(q_in), 32'hA5);
    step();
    check_eq("single_ack", 32'(bus.ack), 32'h4);
    check_eq("single_err", 32'(err), 32'h0);
    bus.req = '0;
    step();

    // All requesting: strict rotation, one grant per three cycles.
    apply_reset();
    grant_log.delete();
    bus.req = 4'b1111;
    for (int i = 0; i < 36; i++) begin
      bus.din = $urandom;
      step();
    end
    check_eq("rotate_count", 32'(grant_log.size()), 32'd12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++)
      check_eq($sformatf("rotate_%0d", i), 32'(grant_log[i]), 32'(i % 4));
    bus.req = '0;
    step();

    // Pointer wrap: after serving 2, requester 3 precedes 0.
    apply_reset();
    bus.req = 4'b0100;
    repeat (3) step();
    bus.req = 4'b1001;
    grant_log.delete();
    repeat (6) step();
    bus.req = '0;
    step();
    check_eq("wrap_first", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF, 32'd3);
    check_eq("wrap_second", (grant_log.size() > 1) ? 32'(grant_log[1]) : 32'hFFFF, 32'd0);

    // Readback mismatch is sticky.
    apply_reset();
    bus.din = {8'h00, 8'h00, 8'h5A, 8'h3C};
    bus.req = 4'b0001;
    step();
    corrupt = 1'b1;
    step();
    step();
    corrupt = 1'b0;
    check_eq("mismatch_err", 32'(err), 32'h1);
    bus.req = 4'b0010;
    repeat (6) step();
    bus.req = '0;
    step();
    check_eq("mismatch_sticky", 32'(err), 32'h1);

    // Reset during LOAD.
    apply_reset();
    bus.req = 4'b1000;
    step();
    check_eq("rst_load_en_before", 32'(en), 32'h1);
    bus.req = '0;
    apply_reset();
    check_eq("rst_load_en", 32'(en), 32'h0);
    check_eq("rst_load_gnt", 32'(bus.gnt), 32'h0);
    check_eq("rst_load_busy", 32'(busy), 32'h0);
    repeat (3) step();
    bus.req = 4'b1111;
    step();
    check_eq("rst_restart_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    repeat (3) step();

    // Request dropped after grant still completes.
    bus.req = 4'b0010;
    bus.din = {8'h00, 8'h00, 8'h77, 8'h00};
    step();
    check_eq("drop_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step();
    step();
    check_eq("drop_ack", 32'(bus.ack), 32'h2);
    step();
    check_eq("drop_idle_busy", 32'(busy), 32'h0);
    check_eq("drop_idle_gnt", 32'(bus.gnt), 32'h0);

    // Random traffic, occasional readback corruption and mid-run reset.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.din = {$urandom};
      corrupt = ($urandom_range(0, 24) == 0);
      if (i == 200) begin
        corrupt = 1'b0;
        apply_reset();
      end
      step();
    end
    corrupt = 1'b0;
    bus.req = '0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
